key_bcd_counter: RTL and testbench

- Upstream stage of the 3-digit seven-segment scanning display; produces the three BCD digits (ge, shi, bai) that the display multiplexes.
- Counts 000..999 from two sources: a free-running prescaled tick (auto mode) and three debounced push-buttons (up, down, clear).
- Replaces the display block's internal counter; the display keeps only segment decode and digit scanning.

---
 rtl/key_bcd_counter_if.sv | 11 +
 rtl/key_bcd_counter.sv | 176 +++++++++++++++++
 tb/tb_key_bcd_counter.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/key_bcd_counter_if.sv
// Digit bus from the key/tick BCD counter to the seven-segment scanning display.
// master drives the digits and the wrap flag, slave is the display side.
interface key_bcd_counter_if;
  logic [3:0] ge;
  logic [3:0] shi;
  logic [3:0] bai;
  logic       wrap;

  modport master (output ge, output shi, output bai, output wrap);
  modport slave  (input  ge, input  shi, input  bai, input  wrap);
endinterface

// File: rtl/key_bcd_counter.sv
// 3-digit BCD counter (000..999) driven by a prescaled auto tick and three debounced keys.
// Define BCD_SATURATE_EN to saturate at 999/000 (wrap then flags the blocked step).
module key_bcd_counter #(
  parameter int TICK_DIV   = 50000000,
  parameter int DEB_CYCLES = 1000000
) (
  input  logic               clk,
  input  logic               res,
  input  logic               key_up,
  input  logic               key_down,
  input  logic               key_clr,
  input  logic               run,
  key_bcd_counter_if.master  disp
);

  localparam int DEB_W  = $clog2(DEB_CYCLES);
  localparam int TICK_W = $clog2(TICK_DIV);
  localparam logic [DEB_W-1:0]  DEB_MAX  = DEB_W'(DEB_CYCLES - 1);
  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(TICK_DIV - 1);

  // Key vectors are ordered {clr, down, up}.
  logic [2:0]       key_raw;
  logic [2:0]       sync1;
  logic [2:0]       sync2;
  logic [2:0]       deb;
  logic [2:0]       deb_q;
  logic [2:0]       ev;
  logic [DEB_W-1:0] deb_cnt [3];

  logic [TICK_W-1:0] tick_cnt;
  logic              tick;

  logic [3:0] ge_q, shi_q, bai_q;
  logic       wrap_q;
  logic [3:0] inc_ge, inc_shi, inc_bai;
  logic [3:0] dec_ge, dec_shi, dec_bai;
  logic       at_max, at_min;
  logic       do_inc, do_dec;

  assign key_raw = {key_clr, key_down, key_up};

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      sync1 <= 3'b111;
      sync2 <= 3'b111;
    end else begin
      sync1 <= key_raw;
      sync2 <= sync1;
    end
  end

  // A level is accepted only after DEB_CYCLES consecutive cycles of disagreement.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      deb   <= 3'b111;
      deb_q <= 3'b111;
      ev    <= 3'b000;
      for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
    end else begin
      deb_q <= deb;
      ev    <= deb_q & ~deb;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_MAX) begin
          deb[i]     <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign tick = run && (tick_cnt == TICK_MAX);

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      tick_cnt <= '0;
    end else if (ev[2]) begin
      tick_cnt <= '0;
    end else if (run) begin
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
    end
  end

  // Decimal +1 / -1 with per-digit carry and borrow.
  always_comb begin
    inc_ge  = ge_q;
    inc_shi = shi_q;
    inc_bai = bai_q;
    dec_ge  = ge_q;
    dec_shi = shi_q;
    dec_bai = bai_q;
    if (ge_q != 4'd9) begin
      inc_ge = ge_q + 4'd1;
    end else begin
      inc_ge = 4'd0;
      if (shi_q != 4'd9) begin
        inc_shi = shi_q + 4'd1;
      end else begin
        inc_shi = 4'd0;
        inc_bai = (bai_q == 4'd9) ? 4'd0 : bai_q + 4'd1;
      end
    end
    if (ge_q != 4'd0) begin
      dec_ge = ge_q - 4'd1;
    end else begin
      dec_ge = 4'd9;
      if (shi_q != 4'd0) begin
        dec_shi = shi_q - 4'd1;
      end else begin
        dec_shi = 4'd9;
        dec_bai = (bai_q == 4'd0) ? 4'd9 : bai_q - 4'd1;
      end
    end
  end

  assign at_max = (ge_q == 4'd9) && (shi_q == 4'd9) && (bai_q == 4'd9);
  assign at_min = (ge_q == 4'd0) && (shi_q == 4'd0) && (bai_q == 4'd0);
  // A tick colliding with any key event is dropped.
  assign do_inc = (ev[0] & ~ev[1]) | (tick & ~(|ev));
  assign do_dec = ev[1] & ~ev[0];

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      ge_q   <= 4'd0;
      shi_q  <= 4'd0;
      bai_q  <= 4'd0;
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      if (ev[2]) begin
        ge_q  <= 4'd0;
        shi_q <= 4'd0;
        bai_q <= 4'd0;
      end else if (do_inc) begin
`ifdef BCD_SATURATE_EN
        if (at_max) begin
          wrap_q <= 1'b1;
        end else begin
          ge_q  <= inc_ge;
          shi_q <= inc_shi;
          bai_q <= inc_bai;
        end
`else
        ge_q   <= inc_ge;
        shi_q  <= inc_shi;
        bai_q  <= inc_bai;
        wrap_q <= at_max;
`endif
      end else if (do_dec) begin
`ifdef BCD_SATURATE_EN
        if (at_min) begin
          wrap_q <= 1'b1;
        end else begin
          ge_q  <= dec_ge;
          shi_q <= dec_shi;
          bai_q <= dec_bai;
        end
`else
        ge_q   <= dec_ge;
        shi_q  <= dec_shi;
        bai_q  <= dec_bai;
        wrap_q <= at_min;
`endif
      end
    end
  end

  assign disp.ge   = ge_q;
  assign disp.shi  = shi_q;
  assign disp.bai  = bai_q;
  assign disp.wrap = wrap_q;

endmodule

// File: tb/tb_key_bcd_counter.sv
// Directed bench for key_bcd_counter with TICK_DIV=10, DEB_CYCLES=4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_key_bcd_counter;

  localparam logic [2:0] K_UP   = 3'b001;
  localparam logic [2:0] K_DOWN = 3'b010;
  localparam logic [2:0] K_CLR  = 3'b100;

  logic clk;
  logic res;
  logic key_up, key_down, key_clr;
  logic run;
  logic [11:0] digits;

  int n_checks;
  int n_fail;
  int wrap_cnt;

  key_bcd_counter_if disp_if ();

  key_bcd_counter #(
    .TICK_DIV   (10),
    .DEB_CYCLES (4)
  ) dut (
    .clk      (clk),
    .res      (res),
    .key_up   (key_up),
    .key_down (key_down),
    .key_clr  (key_clr),
    .run      (run),
    .disp     (disp_if)
  );

  assign digits = {disp_if.bai, disp_if.shi, disp_if.ge};

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // wrap pulses, counted one edge late so the count never races the stimulus
  always @(posedge clk) begin
    if (res && disp_if.wrap) wrap_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_keys(input logic [2:0] low_mask);
    key_up   = ~low_mask[0];
    key_down = ~low_mask[1];
    key_clr  = ~low_mask[2];
  endtask

  // hold long enough for the event, then release and let the release settle
  task automatic press(input logic [2:0] mask);
    set_keys(mask);
    step(10);
    set_keys(3'b000);
    step(10);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    wrap_cnt = 0;
    res      = 1'b0;
    run      = 1'b1;
    set_keys(3'b000);
    step(3);
    check_eq("rst_digits", digits, 12'h000);
    check_eq("rst_wrap", disp_if.wrap, 1'b0);

    // auto count: one step every 10 cycles
    res = 1'b1;
    step(9);
    check_eq("tick_pre", digits, 12'h000);
    step(1);
    check_eq("tick_first", digits, 12'h001);
    step(90);
    check_eq("tick_100", digits, 12'h010);
    check_eq("tick_nowrap", wrap_cnt, 0);
    run = 1'b0;

    press(K_CLR);
    check_eq("clr_010", digits, 12'h000);
`ifndef BCD_SATURATE_EN
    press(K_DOWN);
    check_eq("down_underflow", digits, 12'h999);
    check_eq("down_wrap_cnt", wrap_cnt, 1);
    press(K_DOWN);
    check_eq("down_998", digits, 12'h998);
    run = 1'b1;
    step(10);
    check_eq("tick_999", digits, 12'h999);
    step(10);
    check_eq("tick_overflow", digits, 12'h000);
    run = 1'b0;
    step(2);
    check_eq("overflow_wrap_cnt", wrap_cnt, 2);
`else
    press(K_DOWN);
    check_eq("sat_down_000", digits, 12'h000);
    check_eq("sat_down_wrap", wrap_cnt, 1);
    run = 1'b1;
    step(9990);
    check_eq("sat_tick_999", digits, 12'h999);
    run = 1'b0;
    check_eq("sat_tick_nowrap", wrap_cnt, 1);
    press(K_UP);
    check_eq("sat_up_999", digits, 12'h999);
    check_eq("sat_up_wrap", wrap_cnt, 2);
`endif

    // glitch rejection and exact key latency
    press(K_CLR);
    check_eq("clr_again", digits, 12'h000);
    set_keys(K_UP);
    step(3);
    set_keys(3'b000);
    step(20);
    check_eq("glitch", digits, 12'h000);
    set_keys(K_UP);
    step(7);
    check_eq("lat_before", digits, 12'h000);
    step(1);
    check_eq("lat_after", digits, 12'h001);
    step(42);
    set_keys(3'b000);
    step(20);
    check_eq("hold_once", digits, 12'h001);

    // up and down together cancel
    press(K_UP | K_DOWN);
    check_eq("updown", digits, 12'h001);

    // clear restarts the tick counter
    run = 1'b1;
    step(560);
    check_eq("to_057", digits, 12'h057);
    step(5);
    run = 1'b0;
    check_eq("hold_057", digits, 12'h057);
    press(K_CLR);
    check_eq("clr_057", digits, 12'h000);
    run = 1'b1;
    step(9);
    check_eq("restart_pre", digits, 12'h000);
    step(1);
    check_eq("restart_tick", digits, 12'h001);

    // key event in the same cycle as a tick: tick dropped
    step(400);
    check_eq("to_041", digits, 12'h041);
    step(2);
    set_keys(K_UP);
    step(7);
    check_eq("coll_before", digits, 12'h041);
    step(1);
    check_eq("coll_key", digits, 12'h042);
    run = 1'b0;
    step(2);
    set_keys(3'b000);
    step(10);
    check_eq("coll_dropped", digits, 12'h042);
    check_eq("wrap_total", wrap_cnt, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
